// File: rtl/alu_seq_unit.sv
// Purpose : 16-bit ALU; add/sub/and/or/shift finish in one cycle, multiply
//           uses a 16-iteration shift-add sequence, LSB of the multiplier first.
// Latency : non-multiply -> done 1 cycle after start; multiply -> done 17 cycles after start.
// Backpr. : none; start is only sampled in IDLE and is ignored in MUL/DONE (no queuing).
// Ports   : clk, rst_n (sync, active-low), start, ALU_ctrl[2:0], a, b -> result, zero,
//           busy (multiply running), done (1-cycle pulse when result/zero update).
// Config  : define ALU_OVF_EN to add the registered overflow flag output ovf.
module alu_seq_unit #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [2:0]        ALU_ctrl,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result,
  output logic              zero,
  output logic              busy,
  output logic              done
`ifdef ALU_OVF_EN
  ,
  output logic              ovf
`endif
);

  localparam int PROD_W = 2 * DATA_W;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_SHL = 3'b100;
  localparam logic [2:0] OP_MUL = 3'b101;

  localparam logic [4:0] LAST_ITER = 5'd15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_q,  state_d;
  logic [DATA_W-1:0]   result_q, result_d;
  logic                zero_q,   zero_d;
  logic                busy_q,   busy_d;
  logic                done_q,   done_d;
  logic [4:0]          cnt_q,    cnt_d;
  logic [PROD_W-1:0]   acc_q,    acc_d;
  logic [PROD_W-1:0]   mcand_q,  mcand_d;
  logic [DATA_W-1:0]   mplier_q, mplier_d;
`ifdef ALU_OVF_EN
  logic                ovf_q,    ovf_d;
  logic                alu_ovf;
`endif

  logic [DATA_W-1:0]   sum;
  logic [DATA_W-1:0]   diff;
  logic [DATA_W-1:0]   alu_res;
  logic [PROD_W-1:0]   acc_next;

  assign sum  = a + b;
  assign diff = a - b;

  // Single-cycle operations are evaluated straight from the inputs on the
  // start cycle, so they need no operand capture.
  always_comb begin
    alu_res = '0;
    case (ALU_ctrl)
      OP_ADD:  alu_res = sum;
      OP_SUB:  alu_res = diff;
      OP_AND:  alu_res = a & b;
      OP_OR:   alu_res = a | b;
      OP_SHL:  alu_res = a << b[3:0];
      default: alu_res = '0;
    endcase
  end

`ifdef ALU_OVF_EN
  // Signed overflow: operands agree in sign (add) or differ (sub) and the
  // result sign differs from operand A.
  always_comb begin
    alu_ovf = 1'b0;
    case (ALU_ctrl)
      OP_ADD:  alu_ovf = (a[DATA_W-1] == b[DATA_W-1]) && (sum[DATA_W-1]  != a[DATA_W-1]);
      OP_SUB:  alu_ovf = (a[DATA_W-1] != b[DATA_W-1]) && (diff[DATA_W-1] != a[DATA_W-1]);
      default: alu_ovf = 1'b0;
    endcase
  end
`endif

  // One shift-add step: add the pre-shifted multiplicand when the current
  // multiplier LSB is set.
  assign acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);

  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    zero_d   = zero_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
`ifdef ALU_OVF_EN
    ovf_d    = ovf_q;
`endif

    case (state_q)
      IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          if (ALU_ctrl == OP_MUL) begin
            state_d  = MUL;
            busy_d   = 1'b1;
            cnt_d    = '0;
            acc_d    = '0;
            mcand_d  = {{(PROD_W-DATA_W){1'b0}}, a};
            mplier_d = b;
          end else begin
            state_d  = DONE;
            result_d = alu_res;
            zero_d   = (alu_res == '0);
            done_d   = 1'b1;
`ifdef ALU_OVF_EN
            ovf_d    = alu_ovf;
`endif
          end
        end
      end

      MUL: begin
        acc_d    = acc_next;
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        if (cnt_q == LAST_ITER) begin
          // Counter parks at 15; it is re-armed on the next multiply start.
          state_d  = DONE;
          busy_d   = 1'b0;
          done_d   = 1'b1;
          result_d = acc_next[DATA_W-1:0];
          zero_d   = (acc_next[DATA_W-1:0] == '0);
`ifdef ALU_OVF_EN
          ovf_d    = |acc_next[PROD_W-1:DATA_W];
`endif
        end else begin
          cnt_d  = cnt_q + 5'd1;
          busy_d = 1'b1;
        end
      end

      DONE: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end

      default: begin
        state_d = IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      result_q <= '0;
      zero_q   <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
`ifdef ALU_OVF_EN
      ovf_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      zero_q   <= zero_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
`ifdef ALU_OVF_EN
      ovf_q    <= ovf_d;
`endif
    end
  end

  assign result = result_q;
  assign zero   = zero_q;
  assign busy   = busy_q;
  assign done   = done_q;
`ifdef ALU_OVF_EN
  assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_alu_seq_unit.sv
// Purpose : self-checking bench for alu_seq_unit; expectations queued at issue,
//           popped and compared when done pulses.
// Latency : checks 1-cycle ops, 17-cycle multiply, reset abort, operand latching.
// Backpr. : n/a (drives start pulses, including ignored ones during a multiply).
`timescale 1ns/1ps
module tb_alu_seq_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [2:0]  ALU_ctrl;
  logic [15:0] a;
  logic [15:0] b;
  logic [15:0] result;
  logic        zero;
  logic        busy;
  logic        done;
`ifdef ALU_OVF_EN
  logic        ovf;
`endif

  always #5 clk = ~clk;

  alu_seq_unit #(.DATA_W(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .ALU_ctrl (ALU_ctrl),
    .a        (a),
    .b        (b),
    .result   (result),
    .zero     (zero),
    .busy     (busy),
    .done     (done)
`ifdef ALU_OVF_EN
    ,
    .ovf      (ovf)
`endif
  );

  typedef struct {
    logic [15:0] res;
    logic        ovf;
    bit          mul;
    string       tag;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Independent reference: multiply done with the native operator on 32 bits.
  function automatic logic [16:0] model(input logic [2:0] c, input logic [15:0] x, input logic [15:0] y);
    logic [31:0] p;
    logic [15:0] r;
    logic        o;
    r = 16'h0;
    o = 1'b0;
    p = 32'h0;
    case (c)
      3'd0: begin r = x + y; o = (x[15] == y[15]) && (r[15] != x[15]); end
      3'd1: begin r = x - y; o = (x[15] != y[15]) && (r[15] != x[15]); end
      3'd2: r = x & y;
      3'd3: r = x | y;
      3'd4: r = x << y[3:0];
      3'd5: begin p = {16'h0, x} * {16'h0, y}; r = p[15:0]; o = |p[31:16]; end
      default: r = 16'h0;
    endcase
    return {o, r};
  endfunction

  // Called at a negedge; drives one start cycle and returns at the next negedge.
  // Operands are scrambled afterwards to prove they were captured.
  task automatic issue(input string tag, input logic [2:0] c, input logic [15:0] x,
                       input logic [15:0] y, input logic [15:0] r, input logic o);
    exp_t e;
    e.res = r;
    e.ovf = o;
    e.mul = (c == 3'b101);
    e.tag = tag;
    sb.push_back(e);
    ALU_ctrl = c;
    a        = x;
    b        = y;
    start    = 1'b1;
    @(negedge clk);
    start    = 1'b0;
    a        = ~x;
    b        = ~y;
    ALU_ctrl = 3'b000;
  endtask

  // Waits (bounded) for done, then compares against the oldest queued entry.
  // With poke set, start is held high with other operands while the op runs.
  task automatic wait_done(input bit poke);
    int   n        = 1;
    int   busy_cnt = 0;
    bit   seen     = 1'b0;
    exp_t e;
    chk("sb_not_empty", (sb.size() > 0) ? 32'd1 : 32'd0, 32'd1);
    if (sb.size() > 0) begin
      e = sb.pop_front();
    end else begin
      e.res = 16'h0; e.ovf = 1'b0; e.mul = 1'b0; e.tag = "none";
    end
    while (n <= 40) begin
      if (done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (busy === 1'b1) busy_cnt++;
      if (poke) begin
        start    = 1'b1;
        ALU_ctrl = 3'b000;
        a        = 16'hFFFF;
        b        = 16'h5555;
      end
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    chk({e.tag, "_done_seen"}, {31'h0, seen}, 32'd1);
    chk({e.tag, "_latency"}, n, e.mul ? 32'd17 : 32'd1);
    chk({e.tag, "_busy_cycles"}, busy_cnt, e.mul ? 32'd16 : 32'd0);
    chk({e.tag, "_busy_at_done"}, {31'h0, busy}, 32'd0);
    chk({e.tag, "_result"}, {16'h0, result}, {16'h0, e.res});
    chk({e.tag, "_zero"}, {31'h0, zero}, {31'h0, (e.res == 16'h0)});
`ifdef ALU_OVF_EN
    chk({e.tag, "_ovf"}, {31'h0, ovf}, {31'h0, e.ovf});
`endif
    @(negedge clk);
    chk({e.tag, "_done_one_cycle"}, {31'h0, done}, 32'd0);
  endtask

  initial begin
    logic [15:0] rx, ry;
    logic [2:0]  rc;
    logic [16:0] m;
    int          done_cnt;

    rst_n    = 1'b0;
    start    = 1'b1;
    ALU_ctrl = 3'b000;
    a        = 16'h0001;
    b        = 16'h0001;

    // Reset state (start held high during reset must be ignored).
    repeat (2) @(negedge clk);
    chk("rst_result", {16'h0, result}, 32'h0);
    chk("rst_zero", {31'h0, zero}, 32'd1);
    chk("rst_busy", {31'h0, busy}, 32'd0);
    chk("rst_done", {31'h0, done}, 32'd0);
`ifdef ALU_OVF_EN
    chk("rst_ovf", {31'h0, ovf}, 32'd0);
`endif
    start = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_no_done", {31'h0, done}, 32'd0);

    // Signed-overflow add.
    issue("add_7fff_1", 3'b000, 16'h7FFF, 16'h0001, 16'h8000, 1'b1);
    wait_done(1'b0);

    // Result holds while idle.
    repeat (3) @(negedge clk);
    chk("hold_result", {16'h0, result}, 32'h8000);
    chk("hold_zero", {31'h0, zero}, 32'd0);

    // Equal operands subtract to zero.
    issue("sub_eq", 3'b001, 16'h1234, 16'h1234, 16'h0000, 1'b0);
    wait_done(1'b0);

    // Multiply with spurious start pulses while busy; back-to-back after sub.
    issue("mul_12_34", 3'b101, 16'h0012, 16'h0034, 16'h03A8, 1'b0);
    wait_done(1'b1);
    repeat (2) begin
      @(negedge clk);
      chk("no_extra_done", {31'h0, done}, 32'd0);
    end

    // Reset in the middle of a multiply: aborted, nothing reported.
    issue("abort", 3'b101, 16'h0003, 16'h0005, 16'h000F, 1'b0);
    if (sb.size() > 0) sb.delete(sb.size() - 1);
    repeat (7) @(negedge clk);
    chk("abort_busy_mid", {31'h0, busy}, 32'd1);
    rst_n    = 1'b0;
    start    = 1'b1;
    ALU_ctrl = 3'b011;
    a        = 16'h00F0;
    b        = 16'h000F;
    @(negedge clk);
    chk("abort_result", {16'h0, result}, 32'h0);
    chk("abort_zero", {31'h0, zero}, 32'd1);
    chk("abort_busy", {31'h0, busy}, 32'd0);
    chk("abort_done", {31'h0, done}, 32'd0);
    rst_n = 1'b1;
    start = 1'b0;
    done_cnt = 0;
    repeat (25) begin
      @(negedge clk);
      if (done === 1'b1) done_cnt++;
    end
    chk("abort_no_done_after", done_cnt, 32'd0);
    chk("abort_result_after", {16'h0, result}, 32'h0);

    // Product with only upper bits set.
    issue("mul_hi_only", 3'b101, 16'h1000, 16'h0100, 16'h0000, 1'b1);
    wait_done(1'b0);

    // Shift uses b[3:0] only; then reserved code yields zero.
    issue("shl_3", 3'b100, 16'h0001, 16'hFFF3, 16'h0008, 1'b0);
    wait_done(1'b0);
    issue("op_111", 3'b111, 16'hABCD, 16'h1234, 16'h0000, 1'b0);
    wait_done(1'b0);

    // Remaining codes and wrap cases.
    issue("and", 3'b010, 16'hF0F0, 16'h3C3C, 16'h3030, 1'b0);
    wait_done(1'b0);
    issue("or", 3'b011, 16'hF000, 16'h000F, 16'hF00F, 1'b0);
    wait_done(1'b0);
    issue("op_110", 3'b110, 16'h5555, 16'h5555, 16'h0000, 1'b0);
    wait_done(1'b0);
    issue("add_wrap", 3'b000, 16'hFFFF, 16'h0002, 16'h0001, 1'b0);
    wait_done(1'b0);
    issue("sub_ovf", 3'b001, 16'h8000, 16'h0001, 16'h7FFF, 1'b1);
    wait_done(1'b0);
    issue("mul_ffff", 3'b101, 16'hFFFF, 16'hFFFF, 16'h0001, 1'b1);
    wait_done(1'b0);

    // Random operations against the reference model.
    for (int i = 0; i < 8; i++) begin
      rx = 16'($urandom);
      ry = 16'($urandom);
      rc = (i % 2 == 0) ? 3'b101 : 3'($urandom_range(0, 7));
      m  = model(rc, rx, ry);
      issue("rand", rc, rx, ry, m[15:0], m[16]);
      wait_done(1'b0);
    end

    chk("sb_drained", sb.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
